mem_access: RTL and testbench

- Memory-stage load/store unit sitting directly downstream of the execute stage.
- Consumes execute results and performs the data-memory transaction over a req/gnt/rvalid bus.
- Aligns store data and byte enables by address; extracts and extends load data per the load selector.
- Holds the pipeline (stall_o) while a transaction is in flight and presents registered write-back results to the WB stage.

---
 rtl/mem_access.sv | 212 +++++++++++++++++++++
 tb/tb_mem_access.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: memory-stage load/store unit. Runs one data-memory transaction per
// memory instruction over a req/gnt/rvalid bus and registers the write-back result.
module mem_access #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] aluout_i,
    input  logic [DW-1:0] data2_i,
    input  logic [4:0]    wa_i,
    input  logic          we_i,
    input  logic          dmemen_i,
    input  logic [3:0]    dmemwe_i,
    input  logic          wdata_sel_i,
    input  logic [3:0]    LD_sel_i,
    output logic          stall_o,
    output logic          mem_req_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [3:0]    mem_we_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_gnt_i,
    input  logic          mem_rvalid_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic [DW-1:0] wb_data_o,
    output logic [4:0]    wa_o,
    output logic          we_o,
    output logic          misalign_o,
    output logic [1:0]    state_dbg_o
);

    // Bus handshake: mem_req_o stays high with addr/we/wdata stable until the
    // cycle mem_gnt_i is sampled high; every granted request (read or write)
    // is answered by exactly one mem_rvalid_i in a later cycle.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [2:0]    funct3_q, funct3_d;
    logic          wsel_q, wsel_d;
    logic [AW-1:0] alu_q, alu_d;
    logic [4:0]    ctx_wa_q, ctx_wa_d;
    logic          ctx_we_q, ctx_we_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic [4:0]    wa_q, wa_d;
    logic          we_q, we_d;
    logic          misalign_q, misalign_d;

    logic          stall_raw;
    logic          is_store;
    logic          acc_half;
    logic          acc_word;
    logic          misaligned;
    logic [3:0]    be_shift;
    logic [DW-1:0] wdata_shift;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [DW-1:0] load_val;
    logic          unused_ld_sel;

    assign unused_ld_sel = LD_sel_i[3];

    // Access size comes from the store mask for stores, from funct3 for loads.
    always_comb begin
        is_store = |dmemwe_i;
        if (is_store) begin
            acc_half = (dmemwe_i == 4'b0011);
            acc_word = (dmemwe_i == 4'b1111);
        end else begin
            acc_half = (LD_sel_i[1:0] == 2'b01);
            acc_word = LD_sel_i[1];
        end
        misaligned  = (acc_half && aluout_i[0]) ||
                      (acc_word && (aluout_i[1:0] != 2'b00));
        be_shift    = dmemwe_i << aluout_i[1:0];
        wdata_shift = data2_i << {aluout_i[1:0], 3'b000};
    end

    always_comb begin
        case (alu_q[1:0])
            2'd0:    ld_byte = mem_rdata_i[7:0];
            2'd1:    ld_byte = mem_rdata_i[15:8];
            2'd2:    ld_byte = mem_rdata_i[23:16];
            default: ld_byte = mem_rdata_i[31:24];
        endcase
        ld_half = alu_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (funct3_q)
            3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_val = {24'h000000, ld_byte};
            3'b101:  load_val = {16'h0000, ld_half};
            default: load_val = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        funct3_d   = funct3_q;
        wsel_d     = wsel_q;
        alu_d      = alu_q;
        ctx_wa_d   = ctx_wa_q;
        ctx_we_d   = ctx_we_q;
        wb_data_d  = wb_data_q;
        wa_d       = wa_q;
        we_d       = we_q;
        misalign_d = 1'b0;
        stall_raw  = 1'b0;
        mem_req_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (dmemen_i) begin
                    if (misaligned) begin
                        // Dropped access: no bus traffic, no register write.
                        misalign_d = 1'b1;
                        wb_data_d  = aluout_i;
                        wa_d       = wa_i;
                        we_d       = 1'b0;
                    end else begin
                        stall_raw = 1'b1;
                        state_d   = S_REQ;
                        addr_d    = {aluout_i[AW-1:2], 2'b00};
                        be_d      = be_shift;
                        wdata_d   = wdata_shift;
                        funct3_d  = LD_sel_i[2:0];
                        wsel_d    = wdata_sel_i;
                        alu_d     = aluout_i;
                        ctx_wa_d  = wa_i;
                        ctx_we_d  = we_i;
                    end
                end else begin
                    wb_data_d = aluout_i;
                    wa_d      = wa_i;
                    we_d      = we_i;
                end
            end
            S_REQ: begin
                stall_raw = 1'b1;
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (mem_rvalid_i) begin
                    state_d   = S_IDLE;
                    wb_data_d = wsel_q ? load_val : alu_q;
                    wa_d      = ctx_wa_q;
                    we_d      = ctx_we_q;
                end else begin
                    stall_raw = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            funct3_q   <= '0;
            wsel_q     <= 1'b0;
            alu_q      <= '0;
            ctx_wa_q   <= '0;
            ctx_we_q   <= 1'b0;
            wb_data_q  <= '0;
            wa_q       <= '0;
            we_q       <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            funct3_q   <= funct3_d;
            wsel_q     <= wsel_d;
            alu_q      <= alu_d;
            ctx_wa_q   <= ctx_wa_d;
            ctx_we_q   <= ctx_we_d;
            wb_data_q  <= wb_data_d;
            wa_q       <= wa_d;
            we_q       <= we_d;
            misalign_q <= misalign_d;
        end
    end

    // Stall is gated by reset so every output reads 0 while rst is held.
    assign stall_o     = stall_raw && !rst;
    assign mem_addr_o  = addr_q;
    assign mem_we_o    = be_q;
    assign mem_wdata_o = wdata_q;
    assign wb_data_o   = wb_data_q;
    assign wa_o        = wa_q;
    assign we_o        = we_q;
    assign misalign_o  = misalign_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, reset corner cases and randomized
// operations checked against a rule-level reference model.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] aluout_i;
    logic [31:0] data2_i;
    logic [4:0]  wa_i;
    logic        we_i;
    logic        dmemen_i;
    logic [3:0]  dmemwe_i;
    logic        wdata_sel_i;
    logic [3:0]  LD_sel_i;
    logic        stall_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] wb_data_o;
    logic [4:0]  wa_o;
    logic        we_o;
    logic        misalign_o;
    logic [1:0]  state_dbg_o;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data2;
        logic [31:0] rdata;
        logic [4:0]  wa;
        logic        we;
        logic        dmemen;
        logic [3:0]  dmemwe;
        logic        wsel;
        logic [3:0]  ld_sel;
        int          gnt_dly;
        int          rv_dly;
        logic [31:0] exp_wb;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_we;
        logic        exp_mis;
    } vec_t;

    mem_access #(.AW(32), .DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .aluout_i     (aluout_i),
        .data2_i      (data2_i),
        .wa_i         (wa_i),
        .we_i         (we_i),
        .dmemen_i     (dmemen_i),
        .dmemwe_i     (dmemwe_i),
        .wdata_sel_i  (wdata_sel_i),
        .LD_sel_i     (LD_sel_i),
        .stall_o      (stall_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .wb_data_o    (wb_data_o),
        .wa_o         (wa_o),
        .we_o         (we_o),
        .misalign_o   (misalign_o),
        .state_dbg_o  (state_dbg_o)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] data2,
                                input logic [31:0] rdata, input logic [4:0] wa,
                                input logic we, input logic dmemen, input logic [3:0] dmemwe,
                                input logic wsel, input logic [3:0] ld_sel,
                                input int gnt_dly, input int rv_dly,
                                input logic [31:0] exp_wb, input logic [3:0] exp_be,
                                input logic [31:0] exp_wdata, input logic exp_we,
                                input logic exp_mis);
        vec_t v;
        v.addr = addr; v.data2 = data2; v.rdata = rdata; v.wa = wa; v.we = we;
        v.dmemen = dmemen; v.dmemwe = dmemwe; v.wsel = wsel; v.ld_sel = ld_sel;
        v.gnt_dly = gnt_dly; v.rv_dly = rv_dly;
        v.exp_wb = exp_wb; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
        v.exp_we = exp_we; v.exp_mis = exp_mis;
        return v;
    endfunction

    // Reference model: derives expectations from the access rules directly.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int idx;
        int size;
        logic [31:0] b;
        logic [31:0] h;
        logic [31:0] ld;
        logic [31:0] tmp;
        r = v;
        idx = int'(v.addr % 32'd4);
        if (v.dmemwe != 4'b0000) size = $countones(v.dmemwe);
        else if (v.ld_sel[1:0] == 2'b00) size = 1;
        else if (v.ld_sel[1:0] == 2'b01) size = 2;
        else size = 4;
        r.exp_mis = v.dmemen && ((idx % size) != 0);
        tmp = {28'h0, v.dmemwe} * (32'd1 << idx);
        r.exp_be = tmp[3:0];
        r.exp_wdata = v.data2 * (32'd1 << (8 * idx));
        b = (v.rdata >> (8 * idx)) & 32'h0000_00FF;
        h = (v.rdata >> (16 * (idx / 2))) & 32'h0000_FFFF;
        case (v.ld_sel[2:0])
            3'b000:  ld = (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'b001:  ld = (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'b100:  ld = b;
            3'b101:  ld = h;
            default: ld = v.rdata;
        endcase
        r.exp_wb = (v.dmemen && v.wsel) ? ld : v.addr;
        r.exp_we = r.exp_mis ? 1'b0 : v.we;
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input vec_t v);
        aluout_i     = v.addr;
        data2_i      = v.data2;
        wa_i         = v.wa;
        we_i         = v.we;
        dmemen_i     = v.dmemen;
        dmemwe_i     = v.dmemwe;
        wdata_sel_i  = v.wsel;
        LD_sel_i     = v.ld_sel;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
    endtask

    task automatic drive_idle(input logic [31:0] alu);
        aluout_i     = alu;
        data2_i      = '0;
        wa_i         = '0;
        we_i         = 1'b0;
        dmemen_i     = 1'b0;
        dmemwe_i     = '0;
        wdata_sel_i  = 1'b0;
        LD_sel_i     = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    // Called at a falling edge; returns at a falling edge with the result sampled.
    task automatic do_op(input vec_t v, input string nm);
        int bad_hold;
        logic [31:0] e;
        bad_hold = 0;
        drive(v);
        #1;
        if (!v.dmemen) begin
            check({nm, " alu stall"}, {31'h0, stall_o}, 32'h0);
            check({nm, " alu req"}, {31'h0, mem_req_o}, 32'h0);
            exp_q.push_back(v.exp_wb);
            @(negedge clk);
        end else if (v.exp_mis) begin
            check({nm, " mis stall"}, {31'h0, stall_o}, 32'h0);
            @(negedge clk);
            check({nm, " mis pulse"}, {31'h0, misalign_o}, 32'h1);
            check({nm, " mis we"}, {31'h0, we_o}, 32'h0);
            check({nm, " mis req"}, {31'h0, mem_req_o}, 32'h0);
            drive_idle(32'h0);
            @(negedge clk);
            check({nm, " mis pulse end"}, {31'h0, misalign_o}, 32'h0);
            return;
        end else begin
            check({nm, " stall issue"}, {31'h0, stall_o}, 32'h1);
            exp_q.push_back(v.exp_wb);
            for (int c = 0; c <= v.gnt_dly; c++) begin
                @(negedge clk);
                if (mem_req_o !== 1'b1 || stall_o !== 1'b1) bad_hold++;
                if (c == 0) begin
                    check({nm, " addr"}, mem_addr_o, v.addr & 32'hFFFF_FFFC);
                    check({nm, " be"}, {28'h0, mem_we_o}, {28'h0, v.exp_be});
                    if (v.dmemwe != 4'b0000)
                        check({nm, " wdata"}, mem_wdata_o, v.exp_wdata);
                end
                mem_gnt_i = (c == v.gnt_dly);
            end
            @(negedge clk);
            mem_gnt_i = 1'b0;
            for (int r = 0; r <= v.rv_dly; r++) begin
                if (r > 0) @(negedge clk);
                if (mem_req_o !== 1'b0 || stall_o !== 1'b1) bad_hold++;
                mem_rvalid_i = (r == v.rv_dly);
                mem_rdata_i  = (r == v.rv_dly) ? v.rdata : $urandom;
            end
            #1;
            check({nm, " stall drop"}, {31'h0, stall_o}, 32'h0);
            check({nm, " req/stall hold"}, bad_hold, 32'h0);
            @(negedge clk);
            mem_rvalid_i = 1'b0;
        end
        if (exp_q.size() == 0) begin
            check({nm, " scoreboard empty"}, 32'h0, 32'h1);
        end else begin
            e = exp_q.pop_front();
            check({nm, " wb_data"}, wb_data_o, e);
        end
        check({nm, " wa"}, {27'h0, wa_o}, {27'h0, v.wa});
        check({nm, " we"}, {31'h0, we_o}, {31'h0, v.exp_we});
        check({nm, " misalign"}, {31'h0, misalign_o}, 32'h0);
    endtask

    // ---------------- test ----------------
    vec_t tbl[15];
    vec_t v;
    int   kind;

    initial begin
        tbl[0]  = mk(32'h1234, 0, 0, 5, 1, 0, 4'b0000, 0, 4'h0, 0, 0, 32'h1234, 4'b0000, 0, 1, 0);
        tbl[1]  = mk(32'h103, 32'hAB, 0, 0, 0, 1, 4'b0001, 0, 4'h0, 1, 1, 32'h103, 4'b1000, 32'hAB00_0000, 0, 0);
        tbl[2]  = mk(32'h202, 0, 32'h0080_FF00, 7, 1, 1, 4'b0000, 1, 4'h0, 0, 0, 32'hFFFF_FF80, 4'b0000, 0, 1, 0);
        tbl[3]  = mk(32'h202, 0, 32'h0080_FF00, 7, 1, 1, 4'b0000, 1, 4'h4, 0, 0, 32'h0000_0080, 4'b0000, 0, 1, 0);
        tbl[4]  = mk(32'h202, 0, 32'h0080_FF00, 8, 1, 1, 4'b0000, 1, 4'h1, 0, 0, 32'h0000_0080, 4'b0000, 0, 1, 0);
        tbl[5]  = mk(32'h400, 0, 32'hCAFE_F00D, 9, 1, 1, 4'b0000, 1, 4'h2, 3, 2, 32'hCAFE_F00D, 4'b0000, 0, 1, 0);
        tbl[6]  = mk(32'h101, 0, 0, 3, 1, 1, 4'b0000, 1, 4'h2, 0, 0, 32'h0, 4'b0000, 0, 0, 1);
        tbl[7]  = mk(32'h202, 32'h1234_ABCD, 0, 0, 0, 1, 4'b0011, 0, 4'h0, 0, 1, 32'h202, 4'b1100, 32'hABCD_0000, 0, 0);
        tbl[8]  = mk(32'h200, 0, 32'h8001_FFFE, 10, 1, 1, 4'b0000, 1, 4'h5, 1, 0, 32'h0000_FFFE, 4'b0000, 0, 1, 0);
        tbl[9]  = mk(32'h200, 0, 32'h8001_FFFE, 11, 1, 1, 4'b0000, 1, 4'h1, 0, 0, 32'hFFFF_FFFE, 4'b0000, 0, 1, 0);
        tbl[10] = mk(32'h102, 32'h55, 0, 0, 1, 1, 4'b1111, 0, 4'h0, 0, 0, 32'h0, 4'b0000, 0, 0, 1);
        tbl[11] = mk(32'h203, 0, 0, 12, 1, 1, 4'b0000, 1, 4'h1, 0, 0, 32'h0, 4'b0000, 0, 0, 1);
        tbl[12] = mk(32'h10, 32'hDEAD_BEEF, 0, 0, 0, 1, 4'b1111, 0, 4'h0, 2, 0, 32'h10, 4'b1111, 32'hDEAD_BEEF, 0, 0);
        tbl[13] = mk(32'h3, 0, 32'h7F00_0000, 13, 1, 1, 4'b0000, 1, 4'h8, 0, 3, 32'h0000_007F, 4'b0000, 0, 1, 0);
        tbl[14] = mk(32'hFFFF_FFFF, 0, 0, 31, 0, 0, 4'b0000, 0, 4'h0, 0, 0, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0);

        // Reset state
        rst = 1'b1;
        drive_idle(32'h0);
        repeat (3) @(negedge clk);
        check("reset wb_data", wb_data_o, 32'h0);
        check("reset outs", {20'h0, stall_o, mem_req_o, we_o, misalign_o, mem_we_o, wa_o},
              32'h0);
        check("reset mem_addr", mem_addr_o, 32'h0);
        check("reset mem_wdata", mem_wdata_o, 32'h0);
        check("reset state", {30'h0, state_dbg_o}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table, applied back to back
        for (int i = 0; i < 15; i++) begin
            do_op(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset while waiting for the response; a late rvalid must be ignored
        drive(mk(32'h300, 0, 0, 14, 1, 1, 4'b0000, 1, 4'h2, 0, 0, 0, 0, 0, 1, 0));
        @(negedge clk);
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        check("pre-reset state RESP", {30'h0, state_dbg_o}, 32'h2);
        rst = 1'b1;
        #1;
        check("midreset wb_data", wb_data_o, 32'h0);
        check("midreset outs", {26'h0, stall_o, mem_req_o, we_o, misalign_o, state_dbg_o},
              32'h0);
        check("midreset wa", {27'h0, wa_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive_idle(32'h0000_7777);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_BEEF;
        @(negedge clk);
        check("late rvalid wb_data", wb_data_o, 32'h0000_7777);
        check("late rvalid we", {31'h0, we_o}, 32'h0);
        check("late rvalid state", {30'h0, state_dbg_o}, 32'h0);
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;

        // Randomized operations against the reference model
        for (int n = 0; n < 60; n++) begin
            kind     = $urandom_range(0, 8);
            v.addr   = $urandom;
            v.data2  = $urandom;
            v.rdata  = $urandom;
            v.wa     = 5'($urandom_range(0, 31));
            v.we     = 1'($urandom_range(0, 1));
            v.dmemen = 1'b1;
            v.dmemwe = 4'b0000;
            v.wsel   = 1'b1;
            v.ld_sel = {1'($urandom_range(0, 1)), 3'b000};
            v.gnt_dly = $urandom_range(0, 3);
            v.rv_dly  = $urandom_range(0, 3);
            case (kind)
                0: v.ld_sel[2:0] = 3'b000;
                1: v.ld_sel[2:0] = 3'b001;
                2: v.ld_sel[2:0] = 3'b010;
                3: v.ld_sel[2:0] = 3'b100;
                4: v.ld_sel[2:0] = 3'b101;
                5: begin v.dmemwe = 4'b0001; v.wsel = 1'b0; end
                6: begin v.dmemwe = 4'b0011; v.wsel = 1'b0; end
                7: begin v.dmemwe = 4'b1111; v.wsel = 1'b0; end
                default: begin v.dmemen = 1'b0; v.wsel = 1'b0; end
            endcase
            if ($urandom_range(0, 3) != 0) begin
                if (kind == 1 || kind == 4 || kind == 6) v.addr[0] = 1'b0;
                if (kind == 2 || kind == 7) v.addr[1:0] = 2'b00;
            end
            v = model(v);
            do_op(v, $sformatf("rnd%0d", n));
        end

        drive_idle(32'h0);
        @(negedge clk);
        check("scoreboard drained", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
